// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock-divider controller.
package clkdiv_pkg;

   // Default width of the ratio and period counter
   localparam int CNT_W_DEF = 8;

   // Smallest divide ratio that produces a meaningful square wave
   localparam int DIV_MIN = 2;

   // Controller run state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

endpackage

// File: rtl/clkdiv_counter.sv
// Period counter and active-ratio register for the clock divider.
// Decodes the period boundary, the clock-enable strobe and the divided clock.
module clkdiv_counter
   import clkdiv_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DIV_INIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] div,
   output logic             boundary,
   output logic             clk_en,
   output logic             div_clk
);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] div_r;
   logic [CNT_W-1:0] last_s;

   // Decode period end, strobe and divided clock from the registered count
   always_comb begin
      last_s   = div_r - CNT_W'(1);
      boundary = run && (cnt_r == last_s);
      clk_en   = boundary;
      div_clk  = run && (cnt_r < (div_r >> 1));
      div      = div_r;
   end

   // Count within the period; hold at zero while idle; latch a new ratio on load
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
         div_r <= CNT_W'(DIV_INIT);
      end else begin
         if (!run || boundary) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (load) begin
            div_r <= load_val;
         end else begin
            div_r <= div_r;
         end
      end
   end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time controller for the clock divider: run/stop FSM plus the
// ratio-change handshake. New ratios land only on a period boundary (or
// immediately while idle) so no output period is ever truncated or stretched.
module clkdiv_ctrl
   import clkdiv_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DIV_INIT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_req,
   input  logic [CNT_W-1:0] i_div,
   output logic             o_ack,
   output logic             o_err,
   output logic             o_busy,
   output logic             o_clk_en,
   output logic             o_div_clk,
   output logic [CNT_W-1:0] o_div
);

   state_t           state_r;
   logic [CNT_W-1:0] pend_q_r;
   logic             pend_v_r;
   logic             ack_r;
   logic             err_r;
   logic             busy_r;

   logic             run_s;
   logic             accept_s;
   logic             reject_s;
   logic             apply_s;
   logic             boundary_s;

   // Handshake decisions: accept a new request, reject a bad ratio, or apply
   always_comb begin
      run_s    = (state_r != ST_IDLE);
      accept_s = i_req && !busy_r && !ack_r;
      reject_s = pend_v_r && (pend_q_r < CNT_W'(DIV_MIN));
      if (pend_v_r && !reject_s) begin
         apply_s = (state_r == ST_IDLE) || boundary_s;
      end else begin
         apply_s = 1'b0;
      end
   end

   clkdiv_counter #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
   ) u_counter (
      .clk      (i_clk),
      .rst      (i_rst),
      .run      (run_s),
      .load     (apply_s),
      .load_val (pend_q_r),
      .div      (o_div),
      .boundary (boundary_s),
      .clk_en   (o_clk_en),
      .div_clk  (o_div_clk)
   );

   // Run/stop FSM together with pending-ratio tracking and ack/err/busy pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r  <= ST_IDLE;
         pend_q_r <= {CNT_W{1'b0}};
         pend_v_r <= 1'b0;
         ack_r    <= 1'b0;
         err_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: state_r <= i_en ? ST_RUN : ST_IDLE;
            ST_RUN:  state_r <= i_en ? ST_RUN : ST_STOP;
            ST_STOP: begin
               // a re-enable before the final boundary resumes seamlessly
               if (i_en) begin
                  state_r <= ST_RUN;
               end else if (boundary_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_STOP;
               end
            end
            default: state_r <= ST_IDLE;
         endcase

         ack_r <= reject_s || apply_s;
         err_r <= reject_s;

         if (accept_s) begin
            pend_q_r <= i_div;
            pend_v_r <= 1'b1;
            busy_r   <= 1'b1;
         end else if (reject_s || apply_s) begin
            pend_q_r <= pend_q_r;
            pend_v_r <= 1'b0;
            busy_r   <= 1'b0;
         end else begin
            pend_q_r <= pend_q_r;
            pend_v_r <= pend_v_r;
            busy_r   <= busy_r;
         end
      end
   end

   assign o_ack  = ack_r;
   assign o_err  = err_r;
   assign o_busy = busy_r;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl. Each stimulus step pushes the outputs
// expected in specific later cycles; a negedge monitor pops and compares them.
module tb_clkdiv_ctrl;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          req;
   logic [CW-1:0] div_in;
   logic          ack;
   logic          err;
   logic          busy;
   logic          clk_en;
   logic          div_clk;
   logic [CW-1:0] div_out;

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int            at;
      string         tag;
      logic          ce;
      logic          dc;
      logic          ack;
      logic          err;
      logic          busy;
      logic [CW-1:0] div;
   } exp_t;

   exp_t sb[$];

   clkdiv_ctrl #(
      .CNT_W    (CW),
      .DIV_INIT (4)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_en      (en),
      .i_req     (req),
      .i_div     (div_in),
      .o_ack     (ack),
      .o_err     (err),
      .o_busy    (busy),
      .o_clk_en  (clk_en),
      .o_div_clk (div_clk),
      .o_div     (div_out)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle index: value k after the k-th rising edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic push(input int t, input string tag, input logic ce, input logic dc,
                       input logic a, input logic e, input logic b, input logic [CW-1:0] d);
      exp_t x;
      x.at = t; x.tag = tag; x.ce = ce; x.dc = dc;
      x.ack = a; x.err = e; x.busy = b; x.div = d;
      sb.push_back(x);
   endtask

   // Expected outputs in a running period of ratio n whose count was 0 at cycle org
   task automatic push_per(input int t, input string tag, input int n, input int org,
                           input logic a, input logic e, input logic b);
      int ph;
      ph = (t - org) % n;
      push(t, tag, ph == n - 1, ph < n / 2, a, e, b, CW'(n));
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Monitor: compare every expectation due in this cycle, away from the active edge
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            chk($sformatf("%s@%0d.clk_en", sb[i].tag, cyc), clk_en, sb[i].ce);
            chk($sformatf("%s@%0d.div_clk", sb[i].tag, cyc), div_clk, sb[i].dc);
            chk($sformatf("%s@%0d.ack", sb[i].tag, cyc), ack, sb[i].ack);
            chk($sformatf("%s@%0d.err", sb[i].tag, cyc), err, sb[i].err);
            chk($sformatf("%s@%0d.busy", sb[i].tag, cyc), busy, sb[i].busy);
            chk($sformatf("%s@%0d.div", sb[i].tag, cyc), div_out, sb[i].div);
            sb.delete(i);
         end else if (sb[i].at < cyc) begin
            chk($sformatf("%s@%0d.late", sb[i].tag, sb[i].at), cyc, sb[i].at);
            sb.delete(i);
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want normal end");
      $fatal(1, "watchdog expired");
   end

   // Stimulus sequence
   initial begin
      int c0, org, a, org2, b, d, org3, e, g, org4, r;
      rst = 1'b1; en = 1'b0; req = 1'b0; div_in = 8'd0;

      // reset state
      push(2, "rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
      push(4, "idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
      push(5, "idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
      wait_until(3);
      rst = 1'b0;

      // start at N=4: strobes in cycles 4, 8, 12 after the enable edge
      wait_until(5);
      c0 = cyc; en = 1'b1; org = c0 + 1;
      for (int i = 1; i <= 12; i++) push_per(c0 + i, "start", 4, org, 1'b0, 1'b0, 1'b0);

      // change to 3, accepted while cnt=1; applied at the cnt=3 boundary
      a = c0 + 14;
      wait_until(a);
      req = 1'b1; div_in = 8'd3;
      push_per(a + 1, "chg3_old", 4, org, 1'b0, 1'b0, 1'b1);
      push_per(a + 2, "chg3_old", 4, org, 1'b0, 1'b0, 1'b1);
      org2 = a + 3;
      for (int i = 0; i < 12; i++) push_per(org2 + i, "chg3_new", 3, org2, i == 0, 1'b0, 1'b0);
      wait_until(a + 3);
      req = 1'b0;

      // ratio 1 rejected on the edge after acceptance; output undisturbed
      b = org2 + 13;
      wait_until(b);
      req = 1'b1; div_in = 8'd1;
      for (int i = 1; i <= 6; i++) push_per(b + i, "rej", 3, org2, i == 2, i == 2, i == 1);
      wait_until(b + 2);
      req = 1'b0;

      // change to 5 while running, request made at cnt=0
      wait_until(b + 6);
      d = cyc;
      while ((d - org2) % 3 != 0) d++;
      wait_until(d);
      req = 1'b1; div_in = 8'd5;
      push_per(d + 1, "chg5_old", 3, org2, 1'b0, 1'b0, 1'b1);
      push_per(d + 2, "chg5_old", 3, org2, 1'b0, 1'b0, 1'b1);
      org3 = d + 3;
      for (int i = 0; i <= 5; i++) push_per(org3 + i, "chg5_new", 5, org3, i == 0, 1'b0, 1'b0);
      wait_until(org3);
      req = 1'b0;

      // stop at cnt=0 with a pending ratio 2: final strobe, then idle with ack
      e = org3 + 5;
      wait_until(e);
      en = 1'b0; req = 1'b1; div_in = 8'd2;
      for (int i = 1; i <= 4; i++) push_per(e + i, "stop", 5, org3, 1'b0, 1'b0, 1'b1);
      for (int i = 5; i <= 8; i++) push(e + i, "stop_idle", 1'b0, 1'b0, i == 5, 1'b0, 1'b0, 8'd2);
      wait_until(e + 5);
      req = 1'b0;

      // request 255 while idle: ack two edges later, then run at full width
      g = e + 9;
      wait_until(g);
      req = 1'b1; div_in = 8'd255;
      push(g + 1, "idle255", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
      push(g + 2, "idle255", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255);
      push(g + 3, "idle255", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
      wait_until(g + 2);
      req = 1'b0;
      wait_until(g + 3);
      en = 1'b1; org4 = g + 4;
      push_per(org4 + 0,   "n255", 255, org4, 1'b0, 1'b0, 1'b0);
      push_per(org4 + 126, "n255", 255, org4, 1'b0, 1'b0, 1'b0);
      push_per(org4 + 127, "n255", 255, org4, 1'b0, 1'b0, 1'b0);
      push_per(org4 + 253, "n255", 255, org4, 1'b0, 1'b0, 1'b0);
      push_per(org4 + 254, "n255", 255, org4, 1'b0, 1'b0, 1'b0);
      push_per(org4 + 255, "n255", 255, org4, 1'b0, 1'b0, 1'b0);
      push_per(org4 + 508, "n255", 255, org4, 1'b0, 1'b0, 1'b0);
      push_per(org4 + 509, "n255", 255, org4, 1'b0, 1'b0, 1'b0);
      push_per(org4 + 510, "n255", 255, org4, 1'b0, 1'b0, 1'b0);

      // reset while a request is pending: reset values, and no ack afterwards
      r = org4 + 520;
      wait_until(r);
      req = 1'b1; div_in = 8'd7;
      push_per(r + 1, "rst_busy", 255, org4, 1'b0, 1'b0, 1'b1);
      wait_until(r + 1);
      rst = 1'b1;
      for (int i = 2; i <= 10; i++) push(r + i, "rst_busy", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
      wait_until(r + 2);
      rst = 1'b0; req = 1'b0; en = 1'b0;
      wait_until(r + 11);

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
